ham_minmax_engine: RTL and testbench

//  Program-1 datapath engine: reads NUM_WORDS 16-bit operands (2 bytes each) from byte-wide data_mem.

---
 rtl/ham_pkg.sv | 18 +
 rtl/ham_popcount16.sv | 16 +
 rtl/ham_minmax_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_ham_minmax_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared types and constants for the Hamming min/max engine.
// The optional pair-index recording is enabled by defining HAM_PAIR_IDX_EN.
package ham_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_WRITE,
        S_DONE
    } ham_state_e;

    localparam int HAM_DIST_W = 5;

    localparam logic [HAM_DIST_W-1:0] HAM_INIT_MIN = 5'd16;
    localparam logic [HAM_DIST_W-1:0] HAM_INIT_MAX = 5'd0;

endpackage

// File: rtl/ham_popcount16.sv
// Combinational population count of a 16-bit vector (result 0..16).
module ham_popcount16
    import ham_pkg::*;
(
    input  logic [15:0]           vec_i,
    output logic [HAM_DIST_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < 16; i++) begin
            cnt_o = cnt_o + HAM_DIST_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/ham_minmax_engine.sv
// Loads NUM_WORDS 16-bit operands from byte memory, scans all j<k pairs for
// min/max Hamming distance and writes the results back. Define HAM_PAIR_IDX_EN
// to also record and write the (k, j) indices of the winning pairs.
module ham_minmax_engine
    import ham_pkg::*;
#(
    parameter int NUM_WORDS = 32,
    parameter int BASE_ADDR = 0,
    parameter int RES_ADDR  = 64,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata
);

    localparam int NBYTES = 2 * NUM_WORDS;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int IW     = $clog2(NUM_WORDS);
`ifdef HAM_PAIR_IDX_EN
    localparam int NWR    = 6;
`else
    localparam int NWR    = 2;
`endif

    localparam logic [CW-1:0] LOAD_LAST = CW'(NBYTES);
    localparam logic [IW-1:0] LAST_K    = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] LAST_J    = IW'(NUM_WORDS - 2);
    localparam logic [2:0]    WR_LAST   = 3'(NWR - 1);

    ham_state_e             state_q, state_d;
    logic                   start_q;
    logic                   done_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          j_q, j_d;
    logic [IW-1:0]          k_q, k_d;
    logic [2:0]             wcnt_q, wcnt_d;
    logic [HAM_DIST_W-1:0]  min_q, min_d;
    logic [HAM_DIST_W-1:0]  max_q, max_d;
`ifdef HAM_PAIR_IDX_EN
    logic [IW-1:0]          min_j_q, min_j_d, min_k_q, min_k_d;
    logic [IW-1:0]          max_j_q, max_j_d, max_k_q, max_k_d;
`endif

    logic [15:0]            buf_q [NUM_WORDS];
    logic [15:0]            xor_w;
    logic [HAM_DIST_W-1:0]  dist_w;
    logic [IW:0]            byte_idx_w;

    assign xor_w = buf_q[j_q] ^ buf_q[k_q];

    ham_popcount16 u_popcount (
        .vec_i (xor_w),
        .cnt_o (dist_w)
    );

    // Byte read in LOAD cycle n arrives in cycle n+1, so cycle n stores byte n-1.
    assign byte_idx_w = (IW + 1)'(cnt_q - CW'(1));

    // NOTE: the operand buffer has no reset; every run reloads all words before use.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && cnt_q != '0) begin
            if (byte_idx_w[0]) begin
                buf_q[byte_idx_w[IW:1]][7:0]  <= mem_rdata;
            end else begin
                buf_q[byte_idx_w[IW:1]][15:8] <= mem_rdata;
            end
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        j_d       = j_q;
        k_d       = k_q;
        wcnt_d    = wcnt_q;
        min_d     = min_q;
        max_d     = max_q;
`ifdef HAM_PAIR_IDX_EN
        min_j_d   = min_j_q;
        min_k_d   = min_k_q;
        max_j_d   = max_j_q;
        max_k_d   = max_k_q;
`endif
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (start_q && !start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end

            S_LOAD: begin
                if (start) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q < LOAD_LAST) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = AW'(BASE_ADDR) + AW'(cnt_q);
                    end
                    if (cnt_q == LOAD_LAST) begin
                        state_d = S_CMP;
                        j_d     = '0;
                        k_d     = IW'(1);
                        min_d   = HAM_INIT_MIN;
                        max_d   = HAM_INIT_MAX;
`ifdef HAM_PAIR_IDX_EN
                        min_j_d = '0;
                        min_k_d = '0;
                        max_j_d = '0;
                        max_k_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_CMP: begin
                if (start) begin
                    state_d = S_IDLE;
                end else begin
                    // Strict compares keep the first pair in scan order on ties.
                    if (dist_w < min_q) begin
                        min_d   = dist_w;
`ifdef HAM_PAIR_IDX_EN
                        min_j_d = j_q;
                        min_k_d = k_q;
`endif
                    end
                    if (dist_w > max_q) begin
                        max_d   = dist_w;
`ifdef HAM_PAIR_IDX_EN
                        max_j_d = j_q;
                        max_k_d = k_q;
`endif
                    end
                    if (k_q == LAST_K) begin
                        if (j_q == LAST_J) begin
                            state_d = S_WRITE;
                            wcnt_d  = '0;
                        end else begin
                            j_d = j_q + IW'(1);
                            k_d = j_q + IW'(2);
                        end
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end

            S_WRITE: begin
                if (start) begin
                    state_d = S_IDLE;
                end else begin
                    // Suppressed while rst_n is low so a reset never lets a partial result land.
                    mem_wr_en = rst_n;
                    mem_addr  = AW'(RES_ADDR) + AW'(wcnt_q);
                    case (wcnt_q)
                        3'd0:    mem_wdata = 8'(min_q);
                        3'd1:    mem_wdata = 8'(max_q);
`ifdef HAM_PAIR_IDX_EN
                        3'd2:    mem_wdata = 8'(min_k_q);
                        3'd3:    mem_wdata = 8'(min_j_q);
                        3'd4:    mem_wdata = 8'(max_k_q);
                        3'd5:    mem_wdata = 8'(max_j_q);
`endif
                        default: mem_wdata = '0;
                    endcase
                    if (wcnt_q == WR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end

            S_DONE: begin
                if (start) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            wcnt_q  <= '0;
            min_q   <= HAM_INIT_MIN;
            max_q   <= HAM_INIT_MAX;
`ifdef HAM_PAIR_IDX_EN
            min_j_q <= '0;
            min_k_q <= '0;
            max_j_q <= '0;
            max_k_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start;
            done_q  <= (state_d == S_DONE);
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
`ifdef HAM_PAIR_IDX_EN
            min_j_q <= min_j_d;
            min_k_q <= min_k_d;
            max_j_q <= max_j_d;
            max_k_q <= max_k_d;
`endif
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_ham_minmax_engine.sv
// Scoreboard bench for ham_minmax_engine; expected latency and write list
// follow HAM_PAIR_IDX_EN when it is defined for the build.
module tb_ham_minmax_engine;

    localparam int NUMW = 32;
    localparam int RES  = 64;
`ifdef HAM_PAIR_IDX_EN
    localparam int EXP_LAT = 567;
`else
    localparam int EXP_LAT = 563;
`endif

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    logic [7:0]  mem   [256];
    logic [15:0] words [NUMW];
    wr_t         exp_q [$];

    int checks      = 0;
    int errors      = 0;
    int overlap_cnt = 0;
    int wr_cnt      = 0;

    always #5 clk = ~clk;

    ham_minmax_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    // Byte memory: registered read data, one write per cycle.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    // Each DUT write pops the scoreboard and is compared against it.
    always @(negedge clk) begin
        if (mem_rd_en && mem_wr_en) overlap_cnt++;
        if (mem_wr_en) begin
            wr_t e;
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d, no write expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write_sb got addr=%0d data=%0d expected addr=%0d data=%0d",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic set_words(input int kind);
        for (int i = 0; i < NUMW; i++) begin
            case (kind)
                0:       words[i] = 16'h0000;
                1:       words[i] = (i == 0) ? 16'hFFFF : 16'h0000;
                2:       words[i] = {i[4:0], 11'b0};
                default: words[i] = 16'($urandom_range(0, 65535));
            endcase
            mem[2*i]     <= words[i][15:8];
            mem[2*i + 1] <= words[i][7:0];
        end
        mem[RES]     <= 8'd16;
        mem[RES + 1] <= 8'd0;
        @(negedge clk);
    endtask

    task automatic push_expected();
        int mn, mx, mnj, mnk, mxj, mxk, d;
        mn = 16; mx = 0; mnj = 0; mnk = 0; mxj = 0; mxk = 0;
        for (int j = 0; j < NUMW - 1; j++) begin
            for (int k = j + 1; k < NUMW; k++) begin
                d = $countones(words[j] ^ words[k]);
                if (d < mn) begin mn = d; mnj = j; mnk = k; end
                if (d > mx) begin mx = d; mxj = j; mxk = k; end
            end
        end
        exp_q.push_back('{addr: 8'(RES),     data: 8'(mn)});
        exp_q.push_back('{addr: 8'(RES + 1), data: 8'(mx)});
`ifdef HAM_PAIR_IDX_EN
        exp_q.push_back('{addr: 8'(RES + 2), data: 8'(mnk)});
        exp_q.push_back('{addr: 8'(RES + 3), data: 8'(mnj)});
        exp_q.push_back('{addr: 8'(RES + 4), data: 8'(mxk)});
        exp_q.push_back('{addr: 8'(RES + 5), data: 8'(mxj)});
`endif
    endtask

    // Pulses start 1->0 and counts cycles from the first LOAD cycle to done; -1 on timeout.
    task automatic kick_and_wait(output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 1200; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %0b expected 0", done); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b expected 0", mem_rd_en); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b expected 0", mem_wr_en); end
        checks++; if (mem_addr !== 8'd0)  begin errors++; $display("FAIL reset_addr got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got %0d expected 0", mem_wdata); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int lat;
        set_words(0);
        push_expected();
        kick_and_wait(lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL zero_latency got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_pending got %0d expected 0", exp_q.size()); end
        checks++; if (mem[RES] !== 8'd0) begin errors++; $display("FAIL zero_min got %0d expected 0", mem[RES]); end
        checks++; if (mem[RES + 1] !== 8'd0) begin errors++; $display("FAIL zero_max got %0d expected 0", mem[RES + 1]); end
        release_start();
    endtask

    task automatic test_one_hot();
        int lat;
        set_words(1);
        push_expected();
        kick_and_wait(lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL onehot_latency got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (mem[RES] !== 8'd0) begin errors++; $display("FAIL onehot_min got %0d expected 0", mem[RES]); end
        checks++; if (mem[RES + 1] !== 8'h10) begin errors++; $display("FAIL onehot_max got %0d expected 16", mem[RES + 1]); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %0b expected 1", done); end
        release_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_drop got %0b expected 0", done); end
    endtask

    task automatic test_shift_pattern();
        int lat;
        set_words(2);
        push_expected();
        kick_and_wait(lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL shift_latency got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (mem[RES] !== 8'd1) begin errors++; $display("FAIL shift_min got %0d expected 1", mem[RES]); end
        checks++; if (mem[RES + 1] !== 8'd5) begin errors++; $display("FAIL shift_max got %0d expected 5", mem[RES + 1]); end
`ifdef HAM_PAIR_IDX_EN
        checks++; if (mem[RES + 2] !== 8'd1)  begin errors++; $display("FAIL shift_min_k got %0d expected 1", mem[RES + 2]); end
        checks++; if (mem[RES + 3] !== 8'd0)  begin errors++; $display("FAIL shift_min_j got %0d expected 0", mem[RES + 3]); end
        checks++; if (mem[RES + 4] !== 8'd31) begin errors++; $display("FAIL shift_max_k got %0d expected 31", mem[RES + 4]); end
        checks++; if (mem[RES + 5] !== 8'd0)  begin errors++; $display("FAIL shift_max_j got %0d expected 0", mem[RES + 5]); end
`endif
        release_start();
    endtask

    task automatic test_reset_midrun();
        int wr_before;
        int done_seen;
        set_words(2);
        wr_before = wr_cnt;
        done_seen = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        repeat (200) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_mid_done got %0d cycles high expected 0", done_seen); end
        checks++; if (wr_cnt != wr_before) begin errors++; $display("FAIL rst_mid_writes got %0d expected 0", wr_cnt - wr_before); end
        checks++; if (mem[RES] !== 8'd16) begin errors++; $display("FAIL rst_mid_min got %0d expected 16", mem[RES]); end
        checks++; if (mem[RES + 1] !== 8'd0) begin errors++; $display("FAIL rst_mid_max got %0d expected 0", mem[RES + 1]); end
    endtask

    task automatic test_abort_restart();
        int lat;
        int wr_before;
        set_words(1);
        wr_before = wr_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk) start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en got %0b expected 0", mem_rd_en); end
        repeat (600) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %0b expected 0", done); end
        checks++; if (wr_cnt != wr_before) begin errors++; $display("FAIL abort_writes got %0d expected 0", wr_cnt - wr_before); end
        push_expected();
        kick_and_wait(lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL restart_latency got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (mem[RES] !== 8'd0) begin errors++; $display("FAIL restart_min got %0d expected 0", mem[RES]); end
        checks++; if (mem[RES + 1] !== 8'd16) begin errors++; $display("FAIL restart_max got %0d expected 16", mem[RES + 1]); end
        release_start();
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int r = 0; r < 2; r++) begin
            set_words(3);
            push_expected();
            kick_and_wait(lat);
            checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL b2b_latency run %0d got %0d expected %0d", r, lat, EXP_LAT); end
            checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending run %0d got %0d expected 0", r, exp_q.size()); end
            release_start();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop run %0d got %0b expected 0", r, done); end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL rd_wr_overlap got %0d cycles expected 0", overlap_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_one_hot();
        test_shift_pattern();
        test_reset_midrun();
        test_abort_restart();
        test_back_to_back();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
